cb_updn_mod: RTL

CB_UPDN_MOD -- requirements
Module: cb_updn_mod

---
 rtl/cb_updn_mod.sv | 76 +++++++
 1 files changed

// File: rtl/cb_updn_mod.sv
// rtl/cb_updn_mod.sv - cascadable modulo-N up/down counter with load, preset, clear
// Carry/borrow out is combinational so chained stages count with no added latency.
module cb_updn_mod #(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             CAI,
  input  logic             EN,
  input  logic             UP,
  input  logic             LD,
  input  logic             PS,
  input  logic             CS,
  output logic [WIDTH-1:0] Q,
  output logic             CAO,
  output logic             WRAP,
  output logic             LDERR
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_lderr;

  logic             w_term;
  logic             w_count;
  logic             w_ld_oor;
  logic [WIDTH-1:0] w_q_next;

  // Terminal count depends on direction so the cascade sees carry (up) or borrow (down).
  assign w_term   = UP ? (r_q == MAX_Q) : (r_q == '0);
  assign w_count  = CAI & EN;
  assign w_ld_oor = (64'(D) >= MODULUS);

  always_comb begin
    w_q_next = r_q;
    if (UP) begin
      w_q_next = w_term ? '0 : r_q + WIDTH'(1);
    end else begin
      w_q_next = w_term ? MAX_Q : r_q - WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q     <= '0;
      r_wrap  <= 1'b0;
      r_lderr <= 1'b0;
    end else if (PS) begin
      r_q    <= MAX_Q;
      r_wrap <= 1'b0;
    end else if (CS) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else if (LD) begin
      // Out-of-range loads saturate to the top of the count range and latch the error.
      r_q     <= w_ld_oor ? MAX_Q : D;
      r_wrap  <= 1'b0;
      r_lderr <= r_lderr | w_ld_oor;
    end else if (w_count) begin
      r_q    <= w_q_next;
      r_wrap <= w_term;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign Q     = r_q;
  assign CAO   = w_count & w_term;
  assign WRAP  = r_wrap;
  assign LDERR = r_lderr;

endmodule
